// File: rtl/seg_scanner.sv
// seg_scanner: time-multiplexed hex driver for a multi-digit 7-segment display
//   clk        in   system clock, rising edge
//   nReset     in   asynchronous active-low reset
//   en         in   1 = scan, 0 = dark with scan counters cleared
//   value      in   hex value, nibble d drives digit d (digit 0 rightmost)
//   dp_mask    in   bit d lights the decimal point of digit d
//   seg        out  segments {g,f,e,d,c,b,a}, active-low, registered
//   dp         out  decimal point, active-low, registered
//   sel        out  one-hot active-low digit selects, registered
//   frame_done out  high on the last cycle of each frame
module seg_scanner #(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 50000,
    parameter int BLANK    = 4,
    parameter int LZ_BLANK = 1
) (
    input  logic                  clk,
    input  logic                  nReset,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_mask,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     sel,
    output logic                  frame_done
);
    localparam int KW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int DW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] D_LAST = DW'(DIGITS - 1);
    logic [KW-1:0]       div_cnt;
    logic [DW-1:0]       digit;
    logic [4*DIGITS-1:0] shadow;
    logic [DIGITS-1:0]   shadow_dp;
    logic                wrap;
    logic                dark;
    logic                lz;
    logic [3:0]          nib;
    logic [6:0]          seg_d;
    logic [DIGITS-1:0]   sel_d;
    logic                dp_d;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    // The first BLANK cycles of each slot are dark so the previous digit's
    // pattern never ghosts onto the newly selected digit.
    always_comb begin
        wrap       = div_cnt == K_LAST;
        frame_done = en && wrap && digit == D_LAST;
        dark       = !en || div_cnt < KW'(BLANK);
        nib        = shadow[{digit, 2'b00} +: 4];
        lz         = LZ_BLANK != 0 && digit != '0 && (shadow >> {digit, 2'b00}) == '0;
        sel_d      = dark ? '1 : ~(DIGITS'(1) << digit);
        seg_d      = dark || lz ? 7'h7F : ~hex7(nib);
        dp_d       = dark || !shadow_dp[digit];
    end

    // Snapshot lands in the first cycle of digit 0, which is always a dark
    // cycle, so a frame shows one consistent value.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            div_cnt   <= '0;
            digit     <= '0;
            shadow    <= '0;
            shadow_dp <= '0;
            seg       <= 7'h7F;
            dp        <= 1'b1;
            sel       <= '1;
        end else begin
            seg <= seg_d;
            dp  <= dp_d;
            sel <= sel_d;
            if (!en) begin
                div_cnt <= '0;
                digit   <= '0;
            end else begin
                div_cnt <= wrap ? '0 : div_cnt + 1'b1;
                if (wrap)
                    digit <= digit == D_LAST ? '0 : digit + 1'b1;
                if (div_cnt == '0 && digit == '0) begin
                    shadow    <= value;
                    shadow_dp <= dp_mask;
                end
            end
        end
    end
endmodule

// File: tb/tb_seg_scanner.sv
// tb_seg_scanner: self-checking bench for seg_scanner (8 digits, 8-cycle slots, 2 dark cycles)
module tb_seg_scanner;
    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] value;
    logic [7:0]  dp_mask;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  sel;
    logic        frame_done;

    seg_scanner #(.DIGITS(8), .SCAN_DIV(8), .BLANK(2), .LZ_BLANK(1)) dut (
        .clk(clk), .nReset(rst_n), .en(en), .value(value), .dp_mask(dp_mask),
        .seg(seg), .dp(dp), .sel(sel), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: pos counts enabled cycles since the scan (re)started.
    // Slot k = pos%8, digit = (pos/8)%8, frame start when pos%64 == 0.
    logic [6:0]  hexs [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int          pos;
    logic [31:0] m_sh;
    logic [7:0]  m_dp;
    logic [6:0]  e_seg;
    logic [7:0]  e_sel;
    logic        e_dp;

    typedef struct {
        logic [31:0] v;
        logic [7:0]  m;
        int          d;
        logic [6:0]  seg;
        logic [7:0]  sel;
        logic        dp;
    } vec_t;
    vec_t vecs [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic go_dark();
        e_sel = 8'hFF;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
    endtask

    task automatic cyc();
        int k;
        int d;
        @(posedge clk);
        if (!rst_n) begin
            pos = 0; m_sh = 0; m_dp = 0; go_dark();
        end else if (!en) begin
            pos = 0; go_dark();
        end else begin
            k = pos % 8;
            d = (pos / 8) % 8;
            if (pos % 64 == 0) begin
                m_sh = value; m_dp = dp_mask;
            end
            if (k < 2) go_dark();
            else begin
                e_sel = ~(8'd1 << d);
                e_seg = (d > 0 && (m_sh >> (4 * d)) == 0) ? 7'h7F : ~hexs[m_sh[4*d +: 4]];
                e_dp  = ~m_dp[d];
            end
            pos++;
        end
        @(negedge clk);
        chk("model_sel", sel, e_sel);
        chk("model_seg", seg, e_seg);
        chk("model_dp", dp, e_dp);
        chk("model_fd", frame_done, rst_n && en && pos % 64 == 63);
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic areset();
        rst_n = 1'b0;
        #1;
        chk("rst_sel", sel, 8'hFF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_dp", dp, 1'b1);
        chk("rst_fd", frame_done, 1'b0);
        pos = 0; m_sh = 0; m_dp = 0; go_dark();
    endtask

    task automatic restart(input logic [31:0] v, input logic [7:0] m);
        en = 1'b0;
        areset();
        cyc();
        rst_n = 1'b1; en = 1'b1; value = v; dp_mask = m;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int second;
        int cnt;
        rst_n = 1'b0; en = 1'b0; value = '0; dp_mask = '0;
        pos = 0; m_sh = 0; m_dp = 0; go_dark();
        vecs[0]  = '{32'h19071110, 8'h00, 0, 7'h40, 8'hFE, 1'b1};
        vecs[1]  = '{32'h19071110, 8'h00, 1, 7'h79, 8'hFD, 1'b1};
        vecs[2]  = '{32'h19071110, 8'h00, 4, 7'h78, 8'hEF, 1'b1};
        vecs[3]  = '{32'h19071110, 8'h00, 6, 7'h10, 8'hBF, 1'b1};
        vecs[4]  = '{32'h19071110, 8'h00, 7, 7'h79, 8'h7F, 1'b1};
        vecs[5]  = '{32'h000000A0, 8'h00, 0, 7'h40, 8'hFE, 1'b1};
        vecs[6]  = '{32'h000000A0, 8'h00, 1, 7'h08, 8'hFD, 1'b1};
        vecs[7]  = '{32'h000000A0, 8'h00, 2, 7'h7F, 8'hFB, 1'b1};
        vecs[8]  = '{32'h000000A0, 8'h00, 7, 7'h7F, 8'h7F, 1'b1};
        vecs[9]  = '{32'h00000000, 8'h00, 0, 7'h40, 8'hFE, 1'b1};
        vecs[10] = '{32'h00000000, 8'h00, 3, 7'h7F, 8'hF7, 1'b1};
        vecs[11] = '{32'h00000000, 8'h05, 2, 7'h7F, 8'hFB, 1'b0};
        vecs[12] = '{32'h00000000, 8'h05, 1, 7'h7F, 8'hFD, 1'b1};
        vecs[13] = '{32'h0000F000, 8'h00, 3, 7'h0E, 8'hF7, 1'b1};
        run(2);
        // table: dark at slot start, then the active pattern of digit d
        foreach (vecs[i]) begin
            restart(vecs[i].v, vecs[i].m);
            run(8 * vecs[i].d + 1);
            chk("tbl_dark_sel", sel, 8'hFF);
            run(2);
            chk("tbl_sel", sel, vecs[i].sel);
            chk("tbl_seg", seg, vecs[i].seg);
            chk("tbl_dp", dp, vecs[i].dp);
        end
        // frame_done period
        restart(32'h12345678, 8'h00);
        first = -1; second = -1;
        for (int i = 1; i <= 130; i++) begin
            cyc();
            if (frame_done) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
        end
        chk("fd_first", first, 63);
        chk("fd_second", second, 127);
        // mid-frame update is held until the next frame
        restart(32'h11111111, 8'h00);
        run(25);
        value = 32'h22222222;
        run(2);
        chk("mid_d3_seg", seg, 7'h79);
        chk("mid_d3_sel", sel, 8'hF7);
        run(32);
        chk("mid_d7_seg", seg, 7'h79);
        chk("mid_d7_sel", sel, 8'h7F);
        run(8);
        chk("next_d0_seg", seg, 7'h24);
        chk("next_d0_sel", sel, 8'hFE);
        // decimal points and enable drop / re-raise
        restart(32'h12345678, 8'h05);
        run(3);
        chk("dp_d0", dp, 1'b0);
        run(8);
        chk("dp_d1", dp, 1'b1);
        run(8);
        chk("dp_d2", dp, 1'b0);
        run(24);
        chk("en_d5_sel", sel, 8'hDF);
        en = 1'b0;
        run(1);
        chk("en_off_sel", sel, 8'hFF);
        chk("en_off_seg", seg, 7'h7F);
        chk("en_off_dp", dp, 1'b1);
        chk("en_off_fd", frame_done, 1'b0);
        value = 32'h0000ABCD; dp_mask = 8'h00; en = 1'b1;
        run(2);
        chk("en_on_dark", sel, 8'hFF);
        run(1);
        chk("en_on_sel", sel, 8'hFE);
        chk("en_on_seg", seg, 7'h21);
        // async reset mid-slot, then restart from digit 0
        restart(32'h87654321, 8'hFF);
        run(20);
        areset();
        run(2);
        rst_n = 1'b1;
        run(3);
        chk("post_rst_sel", sel, 8'hFE);
        // randomized traffic against the model
        restart($urandom, 8'($urandom));
        cnt = 0;
        repeat (900) begin
            if ($urandom_range(0, 9) == 0) value = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 19) == 0) dp_mask = 8'($urandom);
            if (en && $urandom_range(0, 99) < 2) en = 1'b0;
            else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
            cyc();
            if (frame_done) cnt++;
        end
        chk("rand_frames_seen", cnt > 0, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
